// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, parity modes and the parity helper.
// Intended for reuse by the receiver as well.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    START,
    DATA,
    PAR,
    STOP
  } tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Callers zero-extend narrower words; the extra zeros do not change the XOR.
  function automatic logic parity_bit(input logic [8:0] word, input int parity);
    return (parity == PARITY_ODD) ? ~(^word) : ^word;
  endfunction

endpackage

// File: rtl/uart_tick_detect.sv
// Rising-edge detector turning the divided baud clock into a one-cycle tick.
// A tick fires in the first i_clk cycle that i_baud is seen high.
module uart_tick_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_baud,
  output logic o_tick
);

  logic baud_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) baud_q <= 1'b0;
    else       baud_q <= i_baud;
  end

  assign o_tick = i_baud & ~baud_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit(s).
// Every bit boundary follows a baud tick by one cycle; o_tx comes straight from a register.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int PARITY    = PARITY_NONE
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_baud,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int                CW        = $clog2(DATA_BITS);
  localparam logic [CW-1:0]     LAST_BIT  = CW'(DATA_BITS - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 tick;

  uart_tick_detect u_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_baud (i_baud),
    .o_tick (tick)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d    = state_q;
    sh_d       = sh_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_d      = par_q;
    tx_d       = tx_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        // A tick coinciding with accept is deliberately ignored; WAIT needs a later one.
        if (i_valid) begin
          sh_d    = i_data;
          par_d   = parity_bit(9'(i_data), PARITY);
          state_d = WAIT;
        end
      end
      WAIT: if (tick) begin
        tx_d    = 1'b0;
        state_d = START;
      end
      START: if (tick) begin
        tx_d      = sh_q[0];
        bit_cnt_d = '0;
        state_d   = DATA;
      end
      DATA: if (tick) begin
        if (bit_cnt_q == LAST_BIT) begin
          stop_cnt_d = 1'b0;
          if (PARITY != PARITY_NONE) begin
            tx_d    = par_q;
            state_d = PAR;
          end else begin
            tx_d    = 1'b1;
            state_d = STOP;
          end
        end else begin
          sh_d      = sh_q >> 1;
          tx_d      = sh_q[1];
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      PAR: if (tick) begin
        tx_d       = 1'b1;
        stop_cnt_d = 1'b0;
        state_d    = STOP;
      end
      STOP: if (tick) begin
        if (stop_cnt_q == STOP_LAST) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          stop_cnt_d = stop_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the shift register is reset with the counters so no X can ever reach o_tx.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_busy  = (state_q != IDLE);
  assign o_tx    = tx_q;
  assign o_done  = done_q;

endmodule
